// File: rtl/switch_output_scheduler.sv
// switch_output_scheduler: round-robin packet scheduler sharing one egress port among four ingress streams.
// Optional length limit enabled by defining SWITCH_SCHED_MAX_BEATS_EN.
module switch_output_scheduler #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_last,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [3:0]          grant,
  output logic                trunc
);
`ifdef SWITCH_SCHED_MAX_BEATS_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  typedef enum logic {IDLE, XFER} state_t;
  state_t     state;
  logic [1:0] ptr, owner, sel;
  logic [7:0] cnt;
  logic       xfer, beat, cap;
  assign xfer = state == XFER;
  // lowest rotation offset from ptr wins
  always_comb begin
    sel = ptr;
    for (int k = 3; k >= 0; k--)
      if (in_valid[ptr + 2'(k)]) sel = ptr + 2'(k);
  end
  assign cap       = LIMIT && xfer && cnt == 8'(MAX_BEATS - 1) && !in_last[owner];
  assign out_valid = xfer && in_valid[owner];
  assign out_data  = xfer ? in_data[owner*DATA_W +: DATA_W] : '0;
  assign out_last  = xfer && (in_last[owner] || cap);
  assign in_ready  = xfer ? 4'(out_ready) << owner : 4'b0;
  assign beat      = out_valid && out_ready;
  assign trunc     = beat && cap;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      grant <= '0;
    end else if (!xfer) begin
      if (|in_valid) begin
        state <= XFER;
        owner <= sel;
        grant <= 4'b1 << sel;
        cnt   <= '0;
      end
    end else if (beat) begin
      cnt <= cnt + 8'd1;
      if (out_last) begin
        state <= IDLE;
        ptr   <= owner + 2'd1;
        grant <= '0;
      end
    end
  end
endmodule

// File: tb/tb_switch_output_scheduler.sv
// tb_switch_output_scheduler: scoreboard bench; per-ingress drivers feed queued beats, a monitor checks every egress beat.
module tb_switch_output_scheduler;
  localparam int DW = 32;
  localparam int MB = 4;
  typedef struct {logic [DW-1:0] d; logic l; int gap;} beat_t;
  typedef struct {int src; logic [DW-1:0] d; logic l; logic t; int dt;} exp_t;
  logic          clock, reset, out_ready, out_valid, out_last, trunc;
  logic [3:0]    in_valid, in_last, in_ready, grant, acc;
  logic [4*DW-1:0] in_data;
  logic [DW-1:0] out_data;
  beat_t q[4][$];
  exp_t  exq[$];
  exp_t  e;
  int    compared = 0, mismatched = 0, cyc = 0, last_cyc = -100, t;
  logic  was_last = 0;
  switch_output_scheduler #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .grant(grant), .trunc(trunc));
  initial clock = 0;
  always #5 clock = ~clock;
  function automatic logic [DW-1:0] dat(input int p, input int k);
    return DW'(32'hC0DE_0000 + p * 16 + k);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  task automatic send(input int src, input int p, input int n, input int gi = -1, input int g = 0);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = dat(p, k);
      b.l = (k == n - 1);
      b.gap = (k == gi) ? g : 0;
      q[src].push_back(b);
    end
  endtask
  task automatic ex(input int src, input int p, input int k, input logic l, input logic tr, input int dt);
    exp_t x;
    x.src = src; x.d = dat(p, k); x.l = l; x.t = tr; x.dt = dt;
    exq.push_back(x);
  endtask
  task automatic drain(input bit toggle);
    int n = 0;
    while (exq.size() > 0 && n < 300) begin
      @(posedge clock); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    if (exq.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got %0d pending beats, required 0", exq.size());
      exq.delete();
    end
    out_ready = 1;
    repeat (3) @(posedge clock);
    #1;
  endtask
  // ingress drivers: pop on an accepted beat, honour per-beat bubble counts
  initial begin
    in_valid = 0; in_data = 0; in_last = 0;
    forever begin
      @(negedge clock);
      acc = in_valid & in_ready;
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() == 0) in_valid[i] = 0;
        else if (q[i][0].gap > 0) begin
          in_valid[i] = 0;
          q[i][0].gap = q[i][0].gap - 1;
        end else begin
          in_valid[i] = 1;
          in_data[i*DW +: DW] = q[i][0].d;
          in_last[i] = q[i][0].l;
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        chk("in_ready", {60'd0, in_ready}, {60'd0, grant & {4{out_ready}}});
        chk("out_valid", {63'd0, out_valid}, {63'd0, |(grant & in_valid)});
        if (was_last) chk("idle_gap_grant", {60'd0, grant}, 64'd0);
        was_last = 0;
        if (!(out_valid && out_ready)) chk("trunc_no_beat", {63'd0, trunc}, 64'd0);
        else if (exq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", out_data);
        end else begin
          e = exq.pop_front();
          chk("grant", {60'd0, grant}, 64'(1) << e.src);
          chk("out_data", {32'd0, out_data}, {32'd0, e.d});
          chk("out_last", {63'd0, out_last}, {63'd0, e.l});
          chk("trunc", {63'd0, trunc}, {63'd0, e.t});
          if (e.dt > 0) chk("beat_spacing", 64'(cyc - last_cyc), 64'(e.dt));
          last_cyc = cyc;
          was_last = out_last;
        end
      end
    end
  end
  initial begin
    reset = 1; out_ready = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk("rst_grant", {60'd0, grant}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_trunc", {63'd0, trunc}, 64'd0);
    // all four request single beats: 0,1,2,3,0 with one idle cycle between
    send(0, 1, 1); send(0, 2, 1); send(1, 3, 1); send(2, 4, 1); send(3, 5, 1);
    ex(0, 1, 0, 1, 0, 0); ex(1, 3, 0, 1, 0, 2); ex(2, 4, 0, 1, 0, 2);
    ex(3, 5, 0, 1, 0, 2); ex(0, 2, 0, 1, 0, 2);
    drain(0);
    // ingress 2 completes -> ptr=3, then 0 and 1 request: wrap gives 0 first
    send(2, 10, 1); ex(2, 10, 0, 1, 0, 0);
    drain(0);
    send(0, 11, 1); send(1, 12, 1);
    ex(0, 11, 0, 1, 0, 0); ex(1, 12, 0, 1, 0, 2);
    drain(0);
    // ptr=2: ingress 0 holds the port for 4 beats under toggling backpressure
    send(0, 20, 4); send(1, 21, 2);
    for (int k = 0; k < 4; k++) ex(0, 20, k, k == 3, 0, 0);
    ex(1, 21, 0, 0, 0, 0); ex(1, 21, 1, 1, 0, 0);
    drain(1);
    // ptr=2: ingress 3 bubbles 3 cycles before beat 2; ingress 0 waits
    send(3, 30, 4, 2, 3); send(0, 31, 1);
    ex(3, 30, 0, 0, 0, 0); ex(3, 30, 1, 0, 0, 1); ex(3, 30, 2, 0, 0, 4);
    ex(3, 30, 3, 1, 0, 1); ex(0, 31, 0, 1, 0, 2);
    drain(0);
    // ptr=1 -> ingress 2 completes -> ptr=3; reset during 2nd beat of ingress 3 packet
    send(2, 40, 1); ex(2, 40, 0, 1, 0, 0);
    drain(0);
    send(3, 41, 5); ex(3, 41, 0, 0, 0, 0); ex(3, 41, 1, 0, 0, 1);
    t = 0;
    while (exq.size() > 0 && t < 100) begin
      @(negedge clock); #2;
      t++;
    end
    if (exq.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL reset_wait_timeout: got %0d pending beats, required 0", exq.size());
      exq.delete();
    end
    reset = 1;
    #1;
    chk("abort_grant", {60'd0, grant}, 64'd0);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {60'd0, in_ready}, 64'd0);
    chk("abort_out_data", {32'd0, out_data}, 64'd0);
    for (int i = 0; i < 4; i++) q[i].delete();
    acc = 0;
    @(negedge clock); #3;
    reset = 0;
    // ptr back to 0: ingress 1 beats ingress 3
    send(1, 42, 1); send(3, 43, 1);
    ex(1, 42, 0, 1, 0, 0); ex(3, 43, 0, 1, 0, 2);
    drain(0);
    // 6-beat packet from ingress 0
    send(0, 50, 6);
`ifdef SWITCH_SCHED_MAX_BEATS_EN
    ex(0, 50, 0, 0, 0, 0); ex(0, 50, 1, 0, 0, 1); ex(0, 50, 2, 0, 0, 1);
    ex(0, 50, 3, 1, 1, 1); ex(0, 50, 4, 0, 0, 2); ex(0, 50, 5, 1, 0, 1);
`else
    for (int k = 0; k < 6; k++) ex(0, 50, k, k == 5, 0, k == 0 ? 0 : 1);
`endif
    drain(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
